// File: rtl/frv_pipeline_fetch.sv
// -----------------------------------------------------------------------------
// frv_pipeline_fetch
//
// Instruction fetch stage. Issues word-aligned requests on the instruction
// memory bus and buffers returned words in a small FIFO. The FIFO head is
// presented to decode with its PC. Control-flow changes from the backend flush
// the FIFO and redirect the fetch PC.
//
// Build option:
//   FRV_FETCH_ERR_EN  when defined, imem_error is stored per FIFO entry and
//                     driven on s1_error; when undefined, s1_error is tied to 0
//                     and imem_error is ignored.
//
// Parameters:
//   FRV_PC_RESET_VALUE  first fetch address after reset
//   BUF_DEPTH           FIFO entries, power of two in 2..8
//
// Ports:
//   g_clk, g_resetn      clock, asynchronous active-low reset
//   cf_req, cf_target    control-flow change request and new fetch address
//   cf_ack               control-flow change accepted this cycle
//   imem_cen, imem_addr  memory request and word-aligned address
//   imem_stall           memory cannot accept the request this cycle
//   imem_rdata           response data, one cycle after acceptance
//   imem_error           response error, valid with imem_rdata
//   s1_p_valid           s1_instr / s1_pc / s1_error are valid
//   s1_p_busy            decode cannot accept this cycle
//   s1_instr, s1_pc      instruction word and its address
//   s1_error             fetch bus error for this word
// -----------------------------------------------------------------------------
module frv_pipeline_fetch #(
    parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
    parameter int          BUF_DEPTH          = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        cf_ack,
    output logic        imem_cen,
    output logic [31:0] imem_addr,
    input  logic        imem_stall,
    input  logic        imem_error,
    input  logic [31:0] imem_rdata,
    output logic        s1_p_valid,
    input  logic        s1_p_busy,
    output logic [31:0] s1_instr,
    output logic [31:0] s1_pc,
    output logic        s1_error
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic          fetch_en;
    logic          outstanding;
    logic [31:0]   fpc;
    logic [31:0]   tag_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          accept;
    logic          resp_valid;
    logic          push;
    logic          pop;

    logic [31:0]   buf_data [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];

    logic [1:0]    unused_cf_bits;
    assign unused_cf_bits = cf_target[1:0];

    // The bus answers exactly one cycle after acceptance, so "outstanding"
    // and "response arriving this cycle" are the same flop.
    assign resp_valid = outstanding;

    // Slots already claimed: buffered words plus the one still in flight.
    assign occupancy  = count + CW'(outstanding);

    // fetch_en keeps imem_cen low while reset is asserted and rises on the
    // first clock after release. With cf_req low, occupancy cannot grow
    // during a stall, so cen/addr stay stable; cf_req withdraws a stalled
    // request so the redirect is never blocked by the memory.
    assign imem_cen   = fetch_en && !cf_req && (occupancy < CW'(BUF_DEPTH));
    assign imem_addr  = fpc;
    assign accept     = imem_cen && !imem_stall;

    assign cf_ack     = cf_req && (!outstanding || resp_valid);

    // A response landing in the redirect cycle belongs to the old stream.
    assign push       = resp_valid && !cf_ack;
    assign pop        = s1_p_valid && !s1_p_busy;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fetch_en    <= 1'b0;
            outstanding <= 1'b0;
            fpc         <= FRV_PC_RESET_VALUE;
            tag_addr    <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= accept;
            if (accept) begin
                tag_addr <= fpc;
            end
            if (cf_ack) begin
                fpc <= {cf_target[31:2], 2'b00};
            end else if (accept) begin
                fpc <= fpc + 32'd4;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cf_ack) begin
            // Flush wins over a same-cycle pop; decode still takes that word.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge g_clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= tag_addr;
        end
    end

    assign s1_p_valid = (count != '0);
    assign s1_instr   = s1_p_valid ? buf_data[rd_ptr] : 32'h0;
    assign s1_pc      = s1_p_valid ? buf_pc[rd_ptr]   : 32'h0;

`ifdef FRV_FETCH_ERR_EN
    logic buf_err [BUF_DEPTH];

    always_ff @(posedge g_clk) begin
        if (push) begin
            buf_err[wr_ptr] <= imem_error;
        end
    end

    assign s1_error = s1_p_valid && buf_err[rd_ptr];
`else
    logic unused_imem_error;
    assign unused_imem_error = imem_error;
    assign s1_error          = 1'b0;
`endif

endmodule
